// File: rtl/irq_ctrl.sv
// irq_ctrl - bus-programmable interrupt controller.
//
// Collects N_SRC asynchronous interrupt requests, synchronises them, and
// latches them into PENDING according to a per-source mode (rising edge or
// level). Requests reach the core as PENDING & ENABLE.
//
// Register map (word offsets, bits [N_SRC-1:0] used, upper bits read 0):
//   0 PENDING  read / write-1-to-clear (edge-mode bits only)
//   1 ENABLE   read / write
//   2 MODE     read / write, 1 = rising edge, 0 = level
//   3 RAW      read-only, synchronised src_i
//   4 SWSET    write-only, 1 sets PENDING on edge-mode bits, reads 0
//   5 CLAIM    read: index+1 of lowest PENDING&ENABLE bit (0 if none),
//              and the read clears that bit if it is edge mode
//   6,7        read 0, writes ignored
//
// Ports:
//   clk, rst     system clock, asynchronous active-low reset
//   src_i        raw interrupt requests (may be asynchronous)
//   sel/we/addr/wdata  single-cycle bus access
//   rdata/ack    registered response, one cycle after sel
//   irq_o        per-source requests to the core
//   irq_any      OR of irq_o
module irq_ctrl #(
  parameter int unsigned N_SRC       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic [N_SRC-1:0] irq_o,
  output logic             irq_any
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] raw;
  logic [N_SRC-1:0] raw_prev_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] mode_q;
  logic [31:0]      rdata_q;
  logic             ack_q;

  logic             wr;
  logic             rd;
  logic [N_SRC-1:0] wbits;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] swset;
  logic [N_SRC-1:0] claim_onehot;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] active;
  logic [31:0]      claim_val;
  logic             claim_found;
  logic [31:0]      rd_mux;

  // Write data above N_SRC is intentionally discarded.
  logic wdata_unused;
  assign wdata_unused = ^wdata;

  assign raw    = sync_q[SYNC_STAGES-1];
  assign active = pending_q & enable_q;
  assign irq_o   = active;
  assign irq_any = |active;
  assign rdata   = rdata_q;
  assign ack     = ack_q;

  assign wr    = sel & we;
  assign rd    = sel & ~we;
  assign wbits = wdata[N_SRC-1:0];
  assign w1c   = (wr && addr == 3'd0) ? wbits : '0;
  assign swset = (wr && addr == 3'd4) ? wbits : '0;

  // Lowest index wins; the value returned and the bit cleared come from the
  // same pre-edge state, so they always refer to the same source.
  always_comb begin
    claim_onehot = '0;
    claim_val    = '0;
    claim_found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!claim_found && active[i]) begin
        claim_found     = 1'b1;
        claim_onehot[i] = 1'b1;
        claim_val       = 32'(i + 1);
      end
    end
  end

  assign claim_clr = (rd && addr == 3'd5) ? claim_onehot : '0;

  // Edge bits: set beats clear in the same cycle. Level bits track the
  // synchronised input and ignore software set/clear.
  always_comb begin
    pending_d = (mode_q & ((pending_q & ~(w1c | claim_clr))
                           | (raw & ~raw_prev_q) | swset))
              | (~mode_q & raw);
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0:    rd_mux[N_SRC-1:0] = pending_q;
      3'd1:    rd_mux[N_SRC-1:0] = enable_q;
      3'd2:    rd_mux[N_SRC-1:0] = mode_q;
      3'd3:    rd_mux[N_SRC-1:0] = raw;
      3'd5:    rd_mux = claim_val;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      raw_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      sync_q[0] <= src_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      raw_prev_q <= raw;
      pending_q  <= pending_d;
      if (wr && addr == 3'd1) enable_q <= wbits;
      if (wr && addr == 3'd2) mode_q   <= wbits;
      ack_q   <= sel;
      rdata_q <= rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int N = 16;
  localparam int S = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  src_i;
  logic          sel;
  logic          we;
  logic [2:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic [N-1:0]  irq_o;
  logic          irq_any;

  logic [7:0]    src_i8;
  logic          sel8;
  logic [31:0]   rdata8;
  logic          ack8;
  logic [7:0]    irq_o8;
  logic          irq_any8;

  int npass;
  int ntot;

  // Reference model state
  logic [N-1:0]  m_pend, m_en, m_mode;
  logic [N-1:0]  hist [0:S];   // hist[j]: src_i sampled j+1 edges ago
  logic          m_ack;
  logic [31:0]   m_rdata;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .src_i(src_i), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .irq_o(irq_o), .irq_any(irq_any)
  );

  irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .src_i(src_i8), .sel(sel8), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata8), .ack(ack8), .irq_o(irq_o8), .irq_any(irq_any8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_ack = 1'b0; m_rdata = '0;
    for (int j = 0; j <= S; j++) hist[j] = '0;
  endtask

  // One rising edge of the controller, from the register-map rules.
  task automatic model_edge();
    logic [N-1:0] raw, prev, w1c, sw, clm, pe;
    logic [31:0]  r;
    raw = hist[S-1]; prev = hist[S];
    w1c = '0; sw = '0; clm = '0; r = '0;
    pe = m_pend & m_en;
    if (sel) begin
      if (we) begin
        if (addr == 3'd0) w1c = wdata[N-1:0];
        if (addr == 3'd4) sw  = wdata[N-1:0];
      end else begin
        case (addr)
          3'd0: r = {16'h0, m_pend};
          3'd1: r = {16'h0, m_en};
          3'd2: r = {16'h0, m_mode};
          3'd3: r = {16'h0, raw};
          3'd5: begin
            for (int i = 0; i < N; i++) begin
              if (pe[i]) begin
                r = 32'(i + 1);
                clm[i] = 1'b1;
                break;
              end
            end
          end
          default: r = '0;
        endcase
      end
    end
    for (int b = 0; b < N; b++) begin
      if (m_mode[b]) begin
        if ((raw[b] && !prev[b]) || sw[b]) m_pend[b] = 1'b1;
        else if (w1c[b] || clm[b])         m_pend[b] = 1'b0;
      end else begin
        m_pend[b] = raw[b];
      end
    end
    if (sel && we && addr == 3'd1) m_en   = wdata[N-1:0];
    if (sel && we && addr == 3'd2) m_mode = wdata[N-1:0];
    for (int j = S; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = src_i;
    m_ack = sel;
    m_rdata = r;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    @(negedge clk);
  endtask

  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = w; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    access(1'b1, 3'd2, 32'hFFFF);
    access(1'b1, 3'd1, 32'h00FF);
    access(1'b1, 3'd4, 32'h00FF);
    ntot++;
    if (irq_o !== 16'h00FF) $display("FAIL reset_pre_irq got %h want %h", irq_o, 16'h00FF);
    else npass++;
    // Leave a read in flight so ack is high when reset hits.
    sel = 1'b1; we = 1'b0; addr = 3'd1;
    tick();
    #2 rst = 1'b0;
    #1;
    ntot++;
    if ({irq_o, irq_any, ack, rdata} !== '0)
      $display("FAIL reset_async got irq=%h any=%b ack=%b rdata=%h want all 0", irq_o, irq_any, ack, rdata);
    else npass++;
    model_reset();
    sel = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b1;
    for (int a = 0; a < 3; a++) begin
      access(1'b0, 3'(a), 32'h0);
      ntot++;
      if (ack !== 1'b1 || rdata !== 32'h0)
        $display("FAIL reset_readback addr %0d got ack=%b rdata=%h want ack=1 rdata=0", a, ack, rdata);
      else npass++;
    end
  endtask

  task automatic test_edge_latch();
    access(1'b1, 3'd2, 32'h1);
    access(1'b1, 3'd1, 32'h1);
    src_i[0] = 1'b1;
    tick();
    src_i[0] = 1'b0;
    tick();
    ntot++;
    if (irq_o !== 16'h0) $display("FAIL edge_early got %h want %h", irq_o, 16'h0);
    else npass++;
    tick();
    ntot++;
    if (irq_o !== 16'h0001 || irq_any !== 1'b1)
      $display("FAIL edge_latch got irq=%h any=%b want irq=0001 any=1", irq_o, irq_any);
    else npass++;
    access(1'b1, 3'd0, 32'h1);
    ntot++;
    if (irq_o !== 16'h0 || irq_any !== 1'b0)
      $display("FAIL edge_w1c got irq=%h any=%b want 0", irq_o, irq_any);
    else npass++;
  endtask

  task automatic test_level();
    access(1'b1, 3'd2, 32'h0);
    access(1'b1, 3'd1, 32'h4);
    src_i[2] = 1'b1;
    tick(); tick();
    ntot++;
    if (irq_o !== 16'h0) $display("FAIL level_early got %h want %h", irq_o, 16'h0);
    else npass++;
    tick();
    ntot++;
    if (irq_o !== 16'h0004) $display("FAIL level_follow got %h want %h", irq_o, 16'h0004);
    else npass++;
    access(1'b1, 3'd0, 32'h4);
    ntot++;
    if (irq_o !== 16'h0004) $display("FAIL level_w1c got %h want %h", irq_o, 16'h0004);
    else npass++;
    src_i[2] = 1'b0;
    tick(); tick();
    ntot++;
    if (irq_o !== 16'h0004) $display("FAIL level_hold got %h want %h", irq_o, 16'h0004);
    else npass++;
    tick();
    ntot++;
    if (irq_o !== 16'h0) $display("FAIL level_drop got %h want %h", irq_o, 16'h0);
    else npass++;
  endtask

  task automatic test_claim();
    logic [31:0] want [3];
    want[0] = 32'd4; want[1] = 32'd6; want[2] = 32'd0;
    access(1'b1, 3'd2, 32'hFFFF);
    access(1'b1, 3'd1, 32'h0028);
    access(1'b1, 3'd4, 32'h0028);
    for (int k = 0; k < 3; k++) begin
      access(1'b0, 3'd5, 32'h0);
      ntot++;
      if (rdata !== want[k] || rdata !== m_rdata)
        $display("FAIL claim_%0d got %0d want %0d", k, rdata, want[k]);
      else npass++;
    end
    access(1'b0, 3'd0, 32'h0);
    ntot++;
    if (rdata !== 32'h0) $display("FAIL claim_pending got %h want %h", rdata, 32'h0);
    else npass++;
  endtask

  task automatic test_collision();
    access(1'b1, 3'd1, 32'h2);
    src_i[1] = 1'b1;
    tick(); tick();
    access(1'b1, 3'd0, 32'h2);   // W1C on the same edge the rise lands
    ntot++;
    if (irq_o !== 16'h0002) $display("FAIL collide_set_wins got %h want %h", irq_o, 16'h0002);
    else npass++;
    access(1'b0, 3'd0, 32'h0);
    ntot++;
    if (rdata !== 32'h2) $display("FAIL collide_pending got %h want %h", rdata, 32'h2);
    else npass++;
    access(1'b1, 3'd0, 32'h2);
    ntot++;
    if (irq_o !== 16'h0) $display("FAIL collide_clear got %h want %h", irq_o, 16'h0);
    else npass++;
    src_i[1] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    sel = 1'b1; sel8 = 1'b1; we = 1'b1; addr = 3'd1; wdata = 32'hA5A5;
    tick();
    ntot++;
    if (ack !== 1'b1 || ack8 !== 1'b1) $display("FAIL b2b_ack0 got %b/%b want 1/1", ack, ack8);
    else npass++;
    we = 1'b0; addr = 3'd1;
    tick();
    ntot++;
    if (ack !== 1'b1 || rdata !== 32'h0000A5A5)
      $display("FAIL b2b_read_en got ack=%b rdata=%h want ack=1 rdata=0000a5a5", ack, rdata);
    else npass++;
    ntot++;
    if (ack8 !== 1'b1 || rdata8 !== 32'h000000A5)
      $display("FAIL b2b_read_en8 got ack=%b rdata=%h want ack=1 rdata=000000a5", ack8, rdata8);
    else npass++;
    addr = 3'd7;
    tick();
    ntot++;
    if (ack !== 1'b1 || rdata !== 32'h0)
      $display("FAIL b2b_read7 got ack=%b rdata=%h want ack=1 rdata=0", ack, rdata);
    else npass++;
    sel = 1'b0; sel8 = 1'b0;
    tick();
    ntot++;
    if (ack !== 1'b0 || rdata !== 32'h0 || ack8 !== 1'b0)
      $display("FAIL b2b_idle got ack=%b rdata=%h ack8=%b want 0", ack, rdata, ack8);
    else npass++;
    ntot++;
    if (irq_o8 !== 8'h0 || irq_any8 !== 1'b0)
      $display("FAIL b2b_irq8 got %h/%b want 0/0", irq_o8, irq_any8);
    else npass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      src_i = src_i ^ (N'($urandom) & N'($urandom) & N'($urandom));
      sel   = ($urandom_range(0, 1) == 1);
      we    = ($urandom_range(0, 1) == 1);
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      tick();
      ntot++;
      if (irq_o !== (m_pend & m_en) || irq_any !== |(m_pend & m_en))
        $display("FAIL rand_irq cyc %0d got %h/%b want %h/%b", c, irq_o, irq_any,
                 m_pend & m_en, |(m_pend & m_en));
      else npass++;
      ntot++;
      if (ack !== m_ack || rdata !== m_rdata)
        $display("FAIL rand_bus cyc %0d got ack=%b rdata=%h want ack=%b rdata=%h", c, ack, rdata, m_ack, m_rdata);
      else npass++;
    end
    sel = 1'b0; we = 1'b0;
  endtask

  initial begin
    npass = 0; ntot = 0;
    rst = 1'b0; src_i = '0; src_i8 = '0; sel = 1'b0; sel8 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    rst = 1'b1;
    test_reset();
    test_edge_latch();
    test_level();
    test_claim();
    test_collision();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
